// File: rtl/cv32e40x_pkg.sv
// Shared register-file types for the pair-access read block.
package cv32e40x_pkg;
  typedef logic [4:0]  rf_addr_t;
  typedef logic [31:0] rf_data_t;

  typedef enum logic { RV32I, RV32E } rv32_e;
  typedef enum logic { IDLE, PAIR2 } rf_pair_state_e;

  localparam int RF_PAIR_LANES = 4;
  localparam int RF_NUM_REGS   = 32;

  // Pair partner of a register: flip the LSB (x1 pairs with x0, x15 with x14).
  function automatic rf_addr_t rf_pair_addr(rf_addr_t a);
    return a ^ rf_addr_t'(1);
  endfunction

  // x0 is hardwired to zero and RV32E has no registers above x15.
  function automatic logic rf_addr_legal(rv32_e rv, rf_addr_t a);
    return (a != '0) && !((rv == RV32E) && a[4]);
  endfunction
endpackage

// File: rtl/cv32e40x_rf_pair_access_if.sv
// Request/response and write-port bundle between ID/WB and the register file.
interface cv32e40x_rf_pair_access_if
  import cv32e40x_pkg::*;
#(
  parameter int NUM_WR_PORTS = 2
);
  logic                         req_valid_i;
  logic                         req_ready_o;
  logic                         dualread_i;
  rf_addr_t [1:0]               raddr_i;
  logic                         rsp_valid_o;
  logic                         rsp_ready_i;
  rf_data_t [RF_PAIR_LANES-1:0] rdata_o;
  rf_addr_t [NUM_WR_PORTS-1:0]  waddr_i;
  rf_data_t [NUM_WR_PORTS-1:0]  wdata_i;
  logic [NUM_WR_PORTS-1:0]      we_i;

  modport master (
    output req_valid_i, dualread_i, raddr_i, rsp_ready_i, waddr_i, wdata_i, we_i,
    input  req_ready_o, rsp_valid_o, rdata_o
  );

  modport slave (
    input  req_valid_i, dualread_i, raddr_i, rsp_ready_i, waddr_i, wdata_i, we_i,
    output req_ready_o, rsp_valid_o, rdata_o
  );
endinterface

// File: rtl/cv32e40x_rf_storage.sv
// GPR flop array: NUM_RD combinational read ports with write-through bypass,
// NUM_WR write ports where the higher index wins on a collision.
module cv32e40x_rf_storage
  import cv32e40x_pkg::*;
#(
  parameter int    NUM_RD = 4,
  parameter int    NUM_WR = 2,
  parameter rv32_e RV32   = RV32I
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  rf_addr_t [NUM_RD-1:0] i_raddr,
  output rf_data_t [NUM_RD-1:0] o_rdata,
  input  rf_addr_t [NUM_WR-1:0] i_waddr,
  input  rf_data_t [NUM_WR-1:0] i_wdata,
  input  logic [NUM_WR-1:0]     i_we
);
  rf_data_t [RF_NUM_REGS-1:0] r_mem;
  logic [NUM_WR-1:0]          w_wvalid;

  always_comb begin
    w_wvalid = '0;
    for (int w = 0; w < NUM_WR; w++)
      w_wvalid[w] = i_we[w] && rf_addr_legal(RV32, i_waddr[w]);
  end

  // Later iterations overwrite earlier ones, giving the higher port priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (w_wvalid[w]) r_mem[i_waddr[w]] <= i_wdata[w];
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      o_rdata[p] = r_mem[i_raddr[p]];
      for (int w = 0; w < NUM_WR; w++)
        if (w_wvalid[w] && (i_waddr[w] == i_raddr[p])) o_rdata[p] = i_wdata[w];
      if (!rf_addr_legal(RV32, i_raddr[p])) o_rdata[p] = '0;
    end
  end
endmodule

// File: rtl/cv32e40x_rf_pair_access.sv
// Register-file front end: valid/ready operand and register-pair reads.
// With two physical read ports a pair read is split over an extra PAIR2 cycle.
module cv32e40x_rf_pair_access
  import cv32e40x_pkg::*;
#(
  parameter int    NUM_PHYS_RD_PORTS = 4,    // 2 or 4
  parameter rv32_e RV32              = RV32I,
  parameter int    NUM_WR_PORTS      = 2     // 1 or 2
) (
  input logic                      clk,
  input logic                      rst_n,
  cv32e40x_rf_pair_access_if.slave bus
);
  rf_pair_state_e                    r_state, w_state_nxt;
  logic                              r_rsp_valid, w_rsp_valid_nxt;
  rf_data_t [RF_PAIR_LANES-1:0]      r_rdata, w_rdata_nxt;
  rf_addr_t [NUM_PHYS_RD_PORTS-1:0]  w_port_addr;
  rf_data_t [NUM_PHYS_RD_PORTS-1:0]  w_port_data;
  rf_data_t [RF_PAIR_LANES-1:0]      w_lane;
  rf_data_t [1:0]                    w_held;
  logic                              w_ready, w_accept, w_split;

  assign w_ready  = (r_state == IDLE) && (!r_rsp_valid || bus.rsp_ready_i);
  assign w_accept = bus.req_valid_i && w_ready;
  assign w_split  = (NUM_PHYS_RD_PORTS == 2) && bus.dualread_i;

  cv32e40x_rf_storage #(
    .NUM_RD (NUM_PHYS_RD_PORTS),
    .NUM_WR (NUM_WR_PORTS),
    .RV32   (RV32)
  ) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raddr (w_port_addr),
    .o_rdata (w_port_data),
    .i_waddr (bus.waddr_i),
    .i_wdata (bus.wdata_i),
    .i_we    (bus.we_i)
  );

  if (NUM_PHYS_RD_PORTS == 4) begin : g_rd4
    assign w_port_addr = {rf_pair_addr(bus.raddr_i[1]), rf_pair_addr(bus.raddr_i[0]),
                          bus.raddr_i[1], bus.raddr_i[0]};
    assign w_lane      = w_port_data;
    assign w_held      = '0;
  end else begin : g_rd2
    rf_addr_t [1:0] r_haddr;
    rf_data_t [1:0] r_hdata;

    // First half of a split pair: keep A/B data from the accept cycle and the
    // addresses so PAIR2 can fetch the partners.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_haddr <= '0;
        r_hdata <= '0;
      end else if (w_accept && bus.dualread_i) begin
        r_haddr <= bus.raddr_i;
        r_hdata <= w_port_data;
      end
    end

    assign w_port_addr = (r_state == PAIR2) ?
                         {rf_pair_addr(r_haddr[1]), rf_pair_addr(r_haddr[0])} : bus.raddr_i;
    assign w_lane      = {w_port_data, w_port_data};
    assign w_held      = r_hdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rsp_valid_nxt = r_rsp_valid && !bus.rsp_ready_i;
    w_rdata_nxt     = r_rdata;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_split) begin
            w_state_nxt = PAIR2;
          end else begin
            w_rsp_valid_nxt = 1'b1;
            w_rdata_nxt     = w_lane;
            if (!bus.dualread_i) w_rdata_nxt[3:2] = '0;
          end
        end
      end
      PAIR2: begin
        // All four lanes publish together; partners reflect this cycle's writes.
        w_state_nxt     = IDLE;
        w_rsp_valid_nxt = 1'b1;
        w_rdata_nxt     = {w_lane[3], w_lane[2], w_held[1], w_held[0]};
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready_o = w_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rdata_o     = r_rdata;
endmodule

// File: tb/tb_cv32e40x_rf_pair_access.sv
// Drives three configurations (2-port, 4-port, 2-port RV32E) with one stimulus
// stream and compares each against a per-configuration reference model.
module tb_cv32e40x_rf_pair_access;
  import cv32e40x_pkg::*;

  logic clk, rst_n;
  logic t_req, t_dual, t_rsp_ready;
  rf_addr_t [1:0] t_ra, t_wa;
  rf_data_t [1:0] t_wd;
  logic [1:0] t_we;

  logic         d_ready [3];
  logic         d_valid [3];
  logic [127:0] d_rdata [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  cv32e40x_rf_pair_access_if #(.NUM_WR_PORTS(2)) bus0 ();
  cv32e40x_rf_pair_access_if #(.NUM_WR_PORTS(2)) bus1 ();
  cv32e40x_rf_pair_access_if #(.NUM_WR_PORTS(2)) bus2 ();

  cv32e40x_rf_pair_access #(.NUM_PHYS_RD_PORTS(2), .RV32(RV32I), .NUM_WR_PORTS(2))
    dut_p2 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cv32e40x_rf_pair_access #(.NUM_PHYS_RD_PORTS(4), .RV32(RV32I), .NUM_WR_PORTS(2))
    dut_p4 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  cv32e40x_rf_pair_access #(.NUM_PHYS_RD_PORTS(2), .RV32(RV32E), .NUM_WR_PORTS(2))
    dut_e  (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.req_valid_i = t_req;  assign bus1.req_valid_i = t_req;  assign bus2.req_valid_i = t_req;
  assign bus0.dualread_i  = t_dual; assign bus1.dualread_i  = t_dual; assign bus2.dualread_i  = t_dual;
  assign bus0.raddr_i     = t_ra;   assign bus1.raddr_i     = t_ra;   assign bus2.raddr_i     = t_ra;
  assign bus0.rsp_ready_i = t_rsp_ready; assign bus1.rsp_ready_i = t_rsp_ready; assign bus2.rsp_ready_i = t_rsp_ready;
  assign bus0.waddr_i = t_wa; assign bus1.waddr_i = t_wa; assign bus2.waddr_i = t_wa;
  assign bus0.wdata_i = t_wd; assign bus1.wdata_i = t_wd; assign bus2.wdata_i = t_wd;
  assign bus0.we_i    = t_we; assign bus1.we_i    = t_we; assign bus2.we_i    = t_we;

  assign d_ready[0] = bus0.req_ready_o; assign d_valid[0] = bus0.rsp_valid_o; assign d_rdata[0] = bus0.rdata_o;
  assign d_ready[1] = bus1.req_ready_o; assign d_valid[1] = bus1.rsp_valid_o; assign d_rdata[1] = bus1.rdata_o;
  assign d_ready[2] = bus2.req_ready_o; assign d_valid[2] = bus2.rsp_valid_o; assign d_rdata[2] = bus2.rdata_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_mem [3][32];
  logic [31:0] m_out [3][4];
  logic [31:0] m_l0 [3], m_l1 [3];
  logic [4:0]  m_ha [3], m_hb [3];
  bit          m_busy [3], m_vld [3];

  function automatic int ports_of(int k); return (k == 1) ? 4 : 2; endfunction
  function automatic bit is_e(int k);     return (k == 2);          endfunction

  // Architectural read: zero for x0 / missing RV32E regs, else newest write wins.
  function automatic logic [31:0] m_rd(int k, logic [4:0] a);
    logic [31:0] v;
    v = m_mem[k][a];
    if (t_we[0] && t_wa[0] == a) v = t_wd[0];
    if (t_we[1] && t_wa[1] == a) v = t_wd[1];
    if (a == 5'd0 || (is_e(k) && a[4])) v = 32'h0;
    return v;
  endfunction

  function automatic bit m_ready(int k);
    return !m_busy[k] && (!m_vld[k] || t_rsp_ready);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 32; r++) m_mem[k][r] = 32'h0;
      for (int l = 0; l < 4; l++)  m_out[k][l] = 32'h0;
      m_busy[k] = 0; m_vld[k] = 0;
    end
  endtask

  task automatic m_update();
    for (int k = 0; k < 3; k++) begin
      bit rdy;
      rdy = m_ready(k);
      if (m_busy[k]) begin
        m_out[k][0] = m_l0[k];
        m_out[k][1] = m_l1[k];
        m_out[k][2] = m_rd(k, m_ha[k] ^ 5'd1);
        m_out[k][3] = m_rd(k, m_hb[k] ^ 5'd1);
        m_vld[k] = 1; m_busy[k] = 0;
      end else if (t_req && rdy) begin
        if (t_dual && ports_of(k) == 2) begin
          m_l0[k] = m_rd(k, t_ra[0]); m_l1[k] = m_rd(k, t_ra[1]);
          m_ha[k] = t_ra[0];          m_hb[k] = t_ra[1];
          m_busy[k] = 1; m_vld[k] = 0;
        end else begin
          m_out[k][0] = m_rd(k, t_ra[0]);
          m_out[k][1] = m_rd(k, t_ra[1]);
          m_out[k][2] = t_dual ? m_rd(k, t_ra[0] ^ 5'd1) : 32'h0;
          m_out[k][3] = t_dual ? m_rd(k, t_ra[1] ^ 5'd1) : 32'h0;
          m_vld[k] = 1;
        end
      end else if (t_rsp_ready) begin
        m_vld[k] = 0;
      end
      for (int w = 0; w < 2; w++)
        if (t_we[w] && t_wa[w] != 5'd0 && !(is_e(k) && t_wa[w][4])) m_mem[k][t_wa[w]] = t_wd[w];
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic m_check();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model ready dut%0d", k), 128'(d_ready[k]), 128'(m_ready(k)));
      chk($sformatf("model valid dut%0d", k), 128'(d_valid[k]), 128'(m_vld[k]));
      if (m_vld[k])
        chk($sformatf("model rdata dut%0d", k), d_rdata[k],
            {m_out[k][3], m_out[k][2], m_out[k][1], m_out[k][0]});
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (chk_en) m_check();
    @(posedge clk);
    if (rst_n) m_update();
    #1;
  endtask

  task automatic idle_in();
    t_req = 0; t_dual = 0; t_ra = '0; t_rsp_ready = 1;
    t_we = '0; t_wa = '0; t_wd = '0;
  endtask

  task automatic req(rf_addr_t a, rf_addr_t b, logic dual);
    t_req = 1; t_ra = {b, a}; t_dual = dual;
  endtask

  // ---------------- directed table (checked on the 4-port instance) ----------------
  typedef struct {
    logic [1:0]     we;
    rf_addr_t [1:0] wa;
    rf_data_t [1:0] wd;
    rf_addr_t       a, b;
    logic           dual;
    logic [127:0]   exp;
  } vec_t;

  function automatic vec_t mk(logic [1:0] we, rf_addr_t wa0, rf_data_t wd0, rf_addr_t wa1,
                              rf_data_t wd1, rf_addr_t a, rf_addr_t b, logic dual,
                              rf_data_t e0, rf_data_t e1, rf_data_t e2, rf_data_t e3);
    vec_t v;
    v.we = we; v.wa = {wa1, wa0}; v.wd = {wd1, wd0};
    v.a = a; v.b = b; v.dual = dual; v.exp = {e3, e2, e1, e0};
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    tbl[0] = mk(2'b11, 5, 32'hDEADBEEF, 4, 32'h12345678, 5, 4, 0, 32'hDEADBEEF, 32'h12345678, 0, 0);
    tbl[1] = mk(2'b00, 0, 0, 0, 0,                         5, 4, 0, 32'hDEADBEEF, 32'h12345678, 0, 0);
    tbl[2] = mk(2'b00, 0, 0, 0, 0,                         5, 4, 1, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'hDEADBEEF);
    tbl[3] = mk(2'b11, 7, 32'h1, 7, 32'h2,                 7, 0, 0, 32'h2, 0, 0, 0);
    tbl[4] = mk(2'b00, 0, 0, 0, 0,                         7, 7, 0, 32'h2, 32'h2, 0, 0);
    tbl[5] = mk(2'b10, 0, 0, 0, 32'hFFFFFFFF,              0, 7, 0, 0, 32'h2, 0, 0);
    tbl[6] = mk(2'b01, 6, 32'h66, 0, 0,                    1, 7, 1, 0, 32'h2, 0, 32'h66);
    tbl[7] = mk(2'b01, 20, 32'hAA, 0, 0,                   20, 6, 0, 32'hAA, 32'h66, 0, 0);
    tbl[8] = mk(2'b00, 0, 0, 0, 0,                         20, 21, 1, 32'hAA, 0, 0, 32'hAA);

    // Reset
    rst_n = 0; idle_in(); m_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset valid dut%0d", k), 128'(d_valid[k]), 128'(0));
      chk($sformatf("reset rdata dut%0d", k), d_rdata[k], 128'(0));
    end
    rst_n = 1; chk_en = 1;
    for (int k = 0; k < 3; k++) chk($sformatf("ready after reset dut%0d", k), 128'(d_ready[k]), 128'(1));
    cyc();

    for (int i = 0; i < 9; i++) begin
      idle_in();
      t_we = tbl[i].we; t_wa = tbl[i].wa; t_wd = tbl[i].wd;
      req(tbl[i].a, tbl[i].b, tbl[i].dual);
      cyc();
      chk($sformatf("tbl%0d valid", i), 128'(d_valid[1]), 128'(1));
      chk($sformatf("tbl%0d rdata", i), d_rdata[1], tbl[i].exp);
    end
    idle_in(); cyc();

    // Split pair read on 2 ports vs single-cycle on 4 ports
    req(5, 4, 1); cyc(); idle_in();
    chk("pair2 valid @+1", 128'(d_valid[0]), 128'(0));
    chk("pair2 ready @+1", 128'(d_ready[0]), 128'(0));
    chk("pair4 valid @+1", 128'(d_valid[1]), 128'(1));
    chk("pair4 rdata @+1", d_rdata[1], {32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'hDEADBEEF});
    cyc();
    chk("pair2 valid @+2", 128'(d_valid[0]), 128'(1));
    chk("pair2 rdata @+2", d_rdata[0], {32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'hDEADBEEF});
    chk("pair2 ready @+2", 128'(d_ready[0]), 128'(1));

    // Response backpressure on the 4-port instance
    req(7, 5, 0); cyc();
    for (int i = 0; i < 3; i++) begin
      req(4, 4, 0); t_rsp_ready = 0;
      #1;
      chk($sformatf("hold%0d ready", i), 128'(d_ready[1]), 128'(0));
      chk($sformatf("hold%0d valid", i), 128'(d_valid[1]), 128'(1));
      chk($sformatf("hold%0d rdata", i), d_rdata[1], {64'h0, 32'hDEADBEEF, 32'h2});
      cyc();
    end
    t_rsp_ready = 1;
    #1;
    chk("release ready same cycle", 128'(d_ready[1]), 128'(1));
    cyc(); idle_in();
    chk("release rdata", d_rdata[1], {64'h0, 32'h12345678, 32'h12345678});
    cyc();

    // RV32E instance: upper registers absent, x15 pairs with x14
    t_we = 2'b11; t_wa = {5'd15, 5'd20}; t_wd = {32'hF, 32'hAA}; cyc();
    t_wa = {5'd1, 5'd14}; t_wd = {32'h11, 32'hE}; cyc();
    t_wa = {5'd2, 5'd3};  t_wd = {32'h22, 32'h33}; cyc();
    idle_in(); req(20, 15, 1); cyc(); idle_in(); cyc();
    chk("rv32e x20/x15 pair", d_rdata[2], {32'hE, 32'h0, 32'hF, 32'h0});
    req(1, 3, 1); cyc(); idle_in(); cyc();
    chk("rv32e x1/x3 pair", d_rdata[2], {32'h22, 32'h0, 32'h33, 32'h11});

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      t_req  = ($urandom_range(0, 3) != 0);
      t_dual = $urandom_range(0, 1) != 0;
      for (int p = 0; p < 2; p++)
        t_ra[p] = ($urandom_range(0, 1) != 0) ? rf_addr_t'($urandom_range(0, 7))
                                              : rf_addr_t'($urandom_range(0, 31));
      t_we = 2'($urandom_range(0, 3));
      t_wa[0] = rf_addr_t'($urandom_range(0, 31));
      t_wa[1] = ($urandom_range(0, 3) == 0) ? t_wa[0] : rf_addr_t'($urandom_range(0, 31));
      t_wd = {$urandom, $urandom};
      t_rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    idle_in(); cyc(); cyc();

    // Asynchronous reset while the 2-port instance sits in PAIR2
    req(5, 4, 1); cyc(); idle_in();
    #2 rst_n = 0; chk_en = 0; m_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midreset valid dut%0d", k), 128'(d_valid[k]), 128'(0));
      chk($sformatf("midreset rdata dut%0d", k), d_rdata[k], 128'(0));
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1; chk_en = 1;
    req(5, 4, 1); cyc(); idle_in(); cyc();
    chk("post-reset pair2 valid", 128'(d_valid[0]), 128'(1));
    chk("post-reset pair2 rdata", d_rdata[0], 128'(0));
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cv32e40x_rf_pair_access.md
Name: cv32e40x_rf_pair_access

Overview:
- Next-generation register-file block: owns the GPR storage and serves 2-operand or register-pair (dual-read) requests over a valid/ready handshake.
- Physical read-port count is a parameter. With 4 ports, pair reads complete in one cycle. With 2 ports, pair reads are serialised over two cycles by an FSM.
- Sits between ID operand fetch and the WB write ports. Provides write-through bypass and RV32E address masking.

Parameters:
- NUM_PHYS_RD_PORTS, 4, physical read ports on the storage array; legal values 2 or 4.
- RV32, RV32I, RV32I gives 32 GPRs; RV32E gives 16 GPRs.
- NUM_WR_PORTS, 2, write ports; legal values 1 or 2. Higher index has priority.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  read request valid
- req_ready_o  out  1  block can accept a request
- dualread_i  in  1  pair mode; sampled with the request
- raddr_i[2]  in  2x rf_addr_t  operand addresses A, B
- rsp_valid_o  out  1  response data valid
- rsp_ready_i  in  1  consumer accepts the response
- rdata_o[4]  out  4x rf_data_t  {A, B, A^1, B^1}; lanes 2 and 3 are 0 when not in pair mode
- waddr_i[NUM_WR_PORTS]  in  rf_addr_t  write addresses
- wdata_i[NUM_WR_PORTS]  in  rf_data_t  write data
- we_i[NUM_WR_PORTS]  in  1 each  write enables

Behaviour:
- **Reset:**
  - All GPRs = 0; state = IDLE.
  - rsp_valid_o = 0, rdata_o = all 0.
  - req_ready_o = 1 from the first cycle after reset release.
- **Clocking and reset:** one clock, clk; reset rst_n is asynchronous, active-low. Reset mid-operation aborts any FSM state to IDLE and drops a pending response.
- **x0:** always reads 0; writes to x0 are ignored.
- **RV32E:**
  - Writes with address[4] = 1 are ignored.
  - Reads with address[4] = 1 return 0.
  - The pair of x15 is x14, so address[4] is never produced by the XOR.
- **Write collision:** same address on both ports in the same cycle → the higher port index wins.
- **Bypass:** a read whose address matches an active write in the same cycle returns the write data, with the same priority rule as the write collision. Writes always commit, independent of the handshake.
- **Accept:** acceptance = req_valid_i & req_ready_o. req_ready_o = (state == IDLE) & (~rsp_valid_o | rsp_ready_i).
- **Single-cycle path** (dualread_i = 0, or NUM_PHYS_RD_PORTS = 4):
  - Read in the accept cycle; register the data into rdata_o.
  - rsp_valid_o = 1 on the next cycle (latency 1).
  - Full throughput of 1 request per cycle when rsp_ready_i = 1.
- **Pair path with 2 ports** (dualread_i = 1, NUM_PHYS_RD_PORTS = 2):
  - IDLE --accept--> PAIR2. Lanes 0 and 1 are registered internally; addresses are held.
  - PAIR2 reads A^1 and B^1, including bypass of writes in that cycle, then → IDLE.
  - rsp_valid_o rises the cycle after PAIR2, with all 4 lanes updated together (latency 2).
  - req_ready_o = 0 while in PAIR2.
  - Snapshot rule: lanes 0/1 reflect the accept cycle; lanes 2/3 reflect the PAIR2 cycle.
- **Response hold:** while rsp_valid_o & ~rsp_ready_i, rdata_o and rsp_valid_o are stable. rsp_valid_o clears on rsp_ready_i when no new data arrives in that cycle.
- **Pair lanes:** raddr ^ 1 flips the LSB. x1's pair is x0, which reads 0.

Decomposition:
- Shared package cv32e40x_pkg:
  - rf_addr_t, rf_data_t
  - rv32_e enumeration
  - rf_pair_state_e {IDLE, PAIR2}
  - constant RF_PAIR_LANES = 4
- Sub-module cv32e40x_rf_storage: flop array with NUM_PHYS_RD_PORTS read ports, NUM_WR_PORTS write ports, priority write and bypass.
- The handshake/FSM logic lives in cv32e40x_rf_pair_access.

Test Plan:
- Reset, then write x5=0xDEAD_BEEF and x4=0x1234_5678; request A=5, B=4, dual=0 → next cycle rsp_valid_o=1, lanes {0xDEADBEEF, 0x12345678, 0, 0}.
- NUM_PHYS_RD_PORTS=2, dual=1, A=5, B=4 → req_ready_o=0 for 1 cycle, response at +2, lanes {0xDEADBEEF, 0x12345678, 0x12345678, 0xDEADBEEF}. Repeat with 4 ports → response at +1 with the same lanes.
- Port 0 writes x7=0x1 and port 1 writes x7=0x2 in the same cycle as a read of x7 → read returns 0x2; a later read also returns 0x2. A write to x0 of 0xFFFF_FFFF → x0 still reads 0.
- rsp_ready_i held 0 for 3 cycles → rdata_o stable, req_ready_o=0, no request accepted. Release → next request accepted in the same cycle.
- RV32=RV32E: write x20=0xAA, then read x20 → 0. Dual read of A=1 → lane 2 returns x0 = 0.
- Assert rst_n low while in PAIR2 → rsp_valid_o=0 and rdata_o=0 immediately. After release, a read of x5 returns 0.
